btb_predictor: RTL and testbench

- Parametrised dynamic branch predictor that replaces the pipeline's static not-taken policy.
- Direct-mapped branch target buffer (BTB) with one saturating direction counter per entry.
- Looked up combinationally with the IF-stage PC; trained by the resolved branch or jump in EX.
- Computes mispredict/redirect for the datapath's flush logic and keeps saturating accuracy counters.

---
 rtl/bp_pkg.sv | 31 +++
 rtl/btb_predictor_if.sv | 37 +++
 rtl/sat_counter.sv | 23 ++
 rtl/btb_predictor.sv | 136 +++++++++++++
 tb/tb_btb_predictor.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types, widths and PC field helpers for the branch predictor
package bp_pkg;

  // Datapath, tag and counter widths are fixed here so the entry struct can live in the package.
  localparam int BP_XLEN  = 32;
  localparam int BP_TAG_W = 8;
  localparam int BP_CTR_W = 2;

  localparam logic [BP_CTR_W-1:0] WEAK_NT = BP_CTR_W'((1 << (BP_CTR_W - 1)) - 1);
  localparam logic [BP_CTR_W-1:0] WEAK_T  = BP_CTR_W'(1 << (BP_CTR_W - 1));

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_XLEN-1:0]  target;
    logic [BP_CTR_W-1:0] ctr;
  } btb_entry_t;

  function automatic logic [BP_XLEN-1:0] pc_idx(input logic [BP_XLEN-1:0] pc, input int idx_w);
    logic [BP_XLEN-1:0] mask;
    mask = (BP_XLEN'(1) << idx_w) - BP_XLEN'(1);
    return (pc >> 2) & mask;
  endfunction

  function automatic logic [BP_TAG_W-1:0] pc_tag(input logic [BP_XLEN-1:0] pc, input int idx_w);
    logic [BP_XLEN-1:0] sh;
    sh = pc >> (idx_w + 2);
    return sh[BP_TAG_W-1:0];
  endfunction

endpackage

// File: rtl/btb_predictor_if.sv
// rtl/btb_predictor_if.sv - fetch lookup, EX resolve and statistics signals between pipeline and predictor
interface btb_predictor_if
  import bp_pkg::*;
#(
  parameter int XLEN   = BP_XLEN,
  parameter int STAT_W = 32
);
  logic [XLEN-1:0]   if_pc;
  logic              if_pred_taken;
  logic [XLEN-1:0]   if_pred_target;
  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc;
  logic              ex_is_jump;
  logic              ex_taken;
  logic [XLEN-1:0]   ex_target;
  logic              ex_pred_taken;
  logic [XLEN-1:0]   ex_pred_target;
  logic              mispredict;
  logic [XLEN-1:0]   redirect_pc;
  logic              stat_clear;
  logic [STAT_W-1:0] stat_branches;
  logic [STAT_W-1:0] stat_mispredicts;

  modport master (
    output if_pc, ex_valid, ex_pc, ex_is_jump, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target, stat_clear,
    input  if_pred_taken, if_pred_target, mispredict, redirect_pc,
           stat_branches, stat_mispredicts
  );

  modport slave (
    input  if_pc, ex_valid, ex_pc, ex_is_jump, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target, stat_clear,
    output if_pred_taken, if_pred_target, mispredict, redirect_pc,
           stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - next-state logic for a saturating direction counter
module sat_counter #(
  parameter int W = 2
) (
  input  logic [W-1:0] ctr_i,
  input  logic         inc_i,
  input  logic         dec_i,
  input  logic         max_i,
  output logic [W-1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (max_i) begin
      ctr_o = '1;
    end else if (inc_i && (ctr_i != '1)) begin
      ctr_o = ctr_i + W'(1);
    end else if (dec_i && (ctr_i != '0)) begin
      ctr_o = ctr_i - W'(1);
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// rtl/btb_predictor.sv - direct-mapped BTB with per-entry direction counters, mispredict detect and stats
module btb_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int STAT_W  = 32
) (
  input logic            clk,
  input logic            rst,
  btb_predictor_if.slave bus
);

  localparam int IDX_W = $clog2(ENTRIES);

  btb_entry_t btb_q [ENTRIES];

  logic [IDX_W-1:0]    if_idx;
  logic [IDX_W-1:0]    ex_idx;
  logic [BP_TAG_W-1:0] if_tag;
  logic [BP_TAG_W-1:0] ex_tag;

  assign if_idx = IDX_W'(pc_idx(bus.if_pc, IDX_W));
  assign if_tag = pc_tag(bus.if_pc, IDX_W);
  assign ex_idx = IDX_W'(pc_idx(bus.ex_pc, IDX_W));
  assign ex_tag = pc_tag(bus.ex_pc, IDX_W);

  btb_entry_t         if_entry;
  logic               if_hit;
  logic               pred_taken;

  // Lookup reads the registered table only, so a same-cycle update is seen one cycle later.
  always_comb begin
    if_entry   = btb_q[if_idx];
    if_hit     = if_entry.valid && (if_entry.tag == if_tag);
    pred_taken = if_hit && if_entry.ctr[BP_CTR_W-1];
  end

  assign bus.if_pred_taken  = pred_taken;
  assign bus.if_pred_target = pred_taken ? if_entry.target : bus.if_pc + BP_XLEN'(4);

  btb_entry_t          ex_entry;
  btb_entry_t          entry_d;
  logic                ex_hit;
  logic                upd_en;
  logic [BP_CTR_W-1:0] ctr_base;
  logic [BP_CTR_W-1:0] ctr_nxt;
  logic                ctr_inc;
  logic                ctr_dec;

  always_comb begin
    ex_entry = btb_q[ex_idx];
    ex_hit   = ex_entry.valid && (ex_entry.tag == ex_tag);
    // A fresh allocation starts from WEAK_T; jumps are forced to max below either way.
    ctr_base = ex_hit ? ex_entry.ctr : WEAK_T;
    ctr_inc  = ex_hit && !bus.ex_is_jump && bus.ex_taken;
    ctr_dec  = ex_hit && !bus.ex_is_jump && !bus.ex_taken;
  end

  sat_counter #(.W(BP_CTR_W)) u_ctr (
    .ctr_i (ctr_base),
    .inc_i (ctr_inc),
    .dec_i (ctr_dec),
    .max_i (bus.ex_is_jump),
    .ctr_o (ctr_nxt)
  );

  always_comb begin
    upd_en        = bus.ex_valid && (ex_hit || bus.ex_taken);
    entry_d       = ex_entry;
    entry_d.valid = 1'b1;
    entry_d.tag   = ex_tag;
    entry_d.ctr   = ctr_nxt;
    if (!ex_hit || bus.ex_is_jump || bus.ex_taken) begin
      entry_d.target = bus.ex_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WEAK_NT};
      end
    end else if (upd_en) begin
      btb_q[ex_idx] <= entry_d;
    end
  end

  logic               mispredict;
  logic [BP_XLEN-1:0] redirect_pc;

  always_comb begin
    mispredict  = 1'b0;
    redirect_pc = '0;
    if (bus.ex_valid) begin
      mispredict  = (bus.ex_taken != bus.ex_pred_taken) ||
                    (bus.ex_taken && (bus.ex_pred_target != bus.ex_target));
      redirect_pc = bus.ex_taken ? bus.ex_target : bus.ex_pc + BP_XLEN'(4);
    end
  end

  assign bus.mispredict  = mispredict;
  assign bus.redirect_pc = redirect_pc;

  logic [STAT_W-1:0] branches_q, branches_d;
  logic [STAT_W-1:0] mispredicts_q, mispredicts_d;

  always_comb begin
    branches_d    = branches_q;
    mispredicts_d = mispredicts_q;
    if (bus.stat_clear) begin
      branches_d    = '0;
      mispredicts_d = '0;
    end else if (bus.ex_valid) begin
      if (branches_q != '1) begin
        branches_d = branches_q + STAT_W'(1);
      end
      if (mispredict && (mispredicts_q != '1)) begin
        mispredicts_d = mispredicts_q + STAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branches_q    <= '0;
      mispredicts_q <= '0;
    end else begin
      branches_q    <= branches_d;
      mispredicts_q <= mispredicts_d;
    end
  end

  assign bus.stat_branches    = branches_q;
  assign bus.stat_mispredicts = mispredicts_q;

endmodule

// File: tb/tb_btb_predictor.sv
// tb/tb_btb_predictor.sv - directed and randomized bench for btb_predictor against a table model
module tb_btb_predictor;

  localparam int SW   = 4;
  localparam int SMAX = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  btb_predictor_if #(.XLEN(32), .STAT_W(SW)) bus ();

  btb_predictor #(.ENTRIES(64), .STAT_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference table: 64 entries, index = (pc/4) mod 64, tag = (pc/256) mod 256, counter 0..3.
  bit          m_valid [64];
  logic [31:0] m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_ctr   [64];
  int          m_br;
  int          m_mp;

  function automatic int midx(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  function automatic logic [31:0] mtag(input logic [31:0] pc);
    return (pc / 256) % 256;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 32'd0;
      m_tgt[i]   = 32'd0;
      m_ctr[i]   = 1;
    end
    m_br = 0;
    m_mp = 0;
  endtask

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[midx(pc)] && (m_tag[midx(pc)] == mtag(pc));
  endfunction

  function automatic bit m_pt(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[midx(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
    return m_pt(pc) ? m_tgt[midx(pc)] : pc + 32'd4;
  endfunction

  task automatic model_update(input logic [31:0] pc, input bit jump, input bit taken,
                              input logic [31:0] tgt);
    int i;
    i = midx(pc);
    if (m_hit(pc)) begin
      if (jump) begin
        m_ctr[i] = 3;
        m_tgt[i] = tgt;
      end else if (taken) begin
        m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        m_tgt[i] = tgt;
      end else begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
    end else if (taken) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = mtag(pc);
      m_tgt[i]   = tgt;
      m_ctr[i]   = jump ? 3 : 2;
    end
  endtask

  task automatic set_ex(input logic [31:0] pc, input bit jump, input bit taken,
                        input logic [31:0] tgt, input bit ptk, input logic [31:0] ptg);
    bus.ex_valid       = 1'b1;
    bus.ex_pc          = pc;
    bus.ex_is_jump     = jump;
    bus.ex_taken       = taken;
    bus.ex_target      = tgt;
    bus.ex_pred_taken  = ptk;
    bus.ex_pred_target = ptg;
  endtask

  // One clock: check combinational outputs against the model, clock, advance model, check stats.
  task automatic tick(input string tag);
    bit          exp_mp;
    logic [31:0] exp_rd;
    #1;
    check({tag, ":pred_taken"}, 32'(bus.if_pred_taken), 32'(m_pt(bus.if_pc)));
    check({tag, ":pred_target"}, bus.if_pred_target, m_ptgt(bus.if_pc));
    exp_mp = bus.ex_valid && ((bus.ex_taken != bus.ex_pred_taken) ||
                              (bus.ex_taken && (bus.ex_pred_target != bus.ex_target)));
    exp_rd = !bus.ex_valid ? 32'd0 : (bus.ex_taken ? bus.ex_target : bus.ex_pc + 32'd4);
    check({tag, ":mispredict"}, 32'(bus.mispredict), 32'(exp_mp));
    check({tag, ":redirect"}, bus.redirect_pc, exp_rd);
    @(posedge clk);
    if (bus.stat_clear) begin
      m_br = 0;
      m_mp = 0;
    end else if (bus.ex_valid) begin
      if (m_br < SMAX) m_br++;
      if (exp_mp && (m_mp < SMAX)) m_mp++;
    end
    if (bus.ex_valid) model_update(bus.ex_pc, bus.ex_is_jump, bus.ex_taken, bus.ex_target);
    #1;
    bus.ex_valid   = 1'b0;
    bus.stat_clear = 1'b0;
    check({tag, ":stat_br"}, 32'(bus.stat_branches), 32'(m_br));
    check({tag, ":stat_mp"}, 32'(bus.stat_mispredicts), 32'(m_mp));
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_pc();
    logic [31:0] r;
    r = $urandom();
    return {16'h0, 6'd0, r[1:0], 3'd0, r[4:2], r[6:5]};
  endfunction

  initial begin
    logic [31:0] pc, tgt, ptg, r;
    bit          jump, taken, ptk;

    rst = 1'b1;
    bus.if_pc = 32'h0;
    bus.stat_clear = 1'b0;
    set_ex(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    bus.ex_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    bus.if_pc = 32'h100;
    #1;
    check("reset_pt", 32'(bus.if_pred_taken), 32'd0);
    check("reset_tgt", bus.if_pred_target, 32'h104);
    check("reset_br", 32'(bus.stat_branches), 32'd0);
    tick("reset");

    set_ex(32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
    #1;
    check("alloc_mp", 32'(bus.mispredict), 32'd1);
    check("alloc_rd", bus.redirect_pc, 32'h80);
    tick("alloc");
    #1;
    check("alloc_pt", 32'(bus.if_pred_taken), 32'd1);
    check("alloc_tgt", bus.if_pred_target, 32'h80);
    check("alloc_smp", 32'(bus.stat_mispredicts), 32'd1);
    tick("post_alloc");

    for (int k = 0; k < 4; k++) begin
      set_ex(32'h100, 1'b0, 1'b0, 32'h80, m_pt(32'h100), m_ptgt(32'h100));
      tick("nt");
      #1;
      check($sformatf("nt%0d_pt", k), 32'(bus.if_pred_taken), 32'd0);
    end
    set_ex(32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
    tick("sat_a");
    #1;
    check("nt_sat_a", 32'(bus.if_pred_taken), 32'd0);
    set_ex(32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
    tick("sat_b");
    #1;
    check("nt_sat_b", 32'(bus.if_pred_taken), 32'd1);

    set_ex(32'h1100, 1'b0, 1'b1, 32'h2000, 1'b0, 32'h1104);
    tick("alias");
    #1;
    check("alias_old_pt", 32'(bus.if_pred_taken), 32'd0);
    check("alias_old_tgt", bus.if_pred_target, 32'h104);
    tick("alias_old");
    bus.if_pc = 32'h1100;
    #1;
    check("alias_new_pt", 32'(bus.if_pred_taken), 32'd1);
    check("alias_new_tgt", bus.if_pred_target, 32'h2000);
    tick("alias_new");

    bus.if_pc = 32'h200;
    set_ex(32'h200, 1'b1, 1'b1, 32'h400, 1'b1, 32'h3FC);
    #1;
    check("jump_mp", 32'(bus.mispredict), 32'd1);
    check("jump_rd", bus.redirect_pc, 32'h400);
    tick("jump");
    set_ex(32'h200, 1'b0, 1'b0, 32'h400, 1'b1, 32'h400);
    tick("jump_nt1");
    #1;
    check("jump_ctr3", 32'(bus.if_pred_taken), 32'd1);
    set_ex(32'h200, 1'b0, 1'b0, 32'h400, 1'b1, 32'h400);
    tick("jump_nt2");
    #1;
    check("jump_ctr2", 32'(bus.if_pred_taken), 32'd0);

    bus.if_pc = 32'h300;
    set_ex(32'h300, 1'b0, 1'b1, 32'h600, 1'b0, 32'h304);
    #1;
    check("same_old", 32'(bus.if_pred_taken), 32'd0);
    tick("same");
    #1;
    check("same_new_pt", 32'(bus.if_pred_taken), 32'd1);
    check("same_new_tgt", bus.if_pred_target, 32'h600);

    bus.if_pc = 32'hFFFF_FFFC;
    #1;
    check("wrap_tgt", bus.if_pred_target, 32'h0);
    set_ex(32'h440, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0);
    bus.ex_valid = 1'b0;
    #1;
    check("idle_mp", 32'(bus.mispredict), 32'd0);
    check("idle_rd", bus.redirect_pc, 32'd0);
    tick("idle");

    bus.stat_clear = 1'b1;
    tick("clr");
    for (int k = 0; k < 16; k++) begin
      set_ex(32'h700, 1'b0, 1'b1, 32'h900, 1'b0, 32'h704);
      tick("stat_fill");
    end
    #1;
    check("stat_sat_br", 32'(bus.stat_branches), 32'd15);
    check("stat_sat_mp", 32'(bus.stat_mispredicts), 32'd15);
    set_ex(32'h700, 1'b0, 1'b0, 32'h900, 1'b1, 32'h900);
    bus.stat_clear = 1'b1;
    tick("clr_ev");
    #1;
    check("clr_ev_br", 32'(bus.stat_branches), 32'd0);
    check("clr_ev_mp", 32'(bus.stat_mispredicts), 32'd0);

    bus.if_pc = 32'h1100;
    set_ex(32'h500, 1'b0, 1'b1, 32'hA00, 1'b0, 32'h504);
    #1;
    rst = 1'b1;
    #1;
    check("rst_async_pt", 32'(bus.if_pred_taken), 32'd0);
    check("rst_async_tgt", bus.if_pred_target, 32'h1104);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.ex_valid = 1'b0;
    model_reset();
    @(negedge clk);
    bus.if_pc = 32'h500;
    tick("post_rst");

    for (int c = 0; c < 3000; c++) begin
      bus.if_pc = rnd_pc();
      if ($urandom_range(0, 3) != 0) begin
        pc    = rnd_pc();
        r     = $urandom();
        jump  = (r[2:0] == 3'd0);
        taken = jump ? 1'b1 : r[3];
        tgt   = $urandom();
        if (r[5:4] != 2'd0) begin
          ptk = m_pt(pc);
          ptg = m_ptgt(pc);
        end else begin
          ptk = r[6];
          ptg = $urandom();
        end
        set_ex(pc, jump, taken, tgt, ptk, ptg);
      end
      bus.stat_clear = ($urandom_range(0, 19) == 0);
      tick("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
